// File: rtl/adder_arb_pkg.sv
// Shared constants, FSM encoding and width helper for the adder_arbiter slice.
// Optional feature macro used across this slice: ADD_ARB_OVF_EN.
package adder_arb_pkg;

  localparam int DEF_WL   = 32;
  localparam int DEF_NREQ = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

  // Never narrower than one bit, so NREQ=2 still gets a usable ID field.
  function automatic int idw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester and response channels of adder_arbiter.
// The rsp_ovf signal exists only when ADD_ARB_OVF_EN is defined.
interface adder_arbiter_if
  import adder_arb_pkg::*;
#(
  parameter int WL   = DEF_WL,
  parameter int NREQ = DEF_NREQ
);
  localparam int IDW = idw_of(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*WL-1:0] req_in1;
  logic [NREQ*WL-1:0] req_in2;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [WL-1:0]      rsp_data;
`ifdef ADD_ARB_OVF_EN
  logic               rsp_ovf;
`endif

  modport slave (
    input  req_valid, req_in1, req_in2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
`ifdef ADD_ARB_OVF_EN
    , output rsp_ovf
`endif
  );

  modport master (
    output req_valid, req_in1, req_in2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
`ifdef ADD_ARB_OVF_EN
    , input rsp_ovf
`endif
  );

endinterface

// File: rtl/adder.sv
// Plain WL-bit adder; carry-out is discarded.
module adder #(
  parameter int WL = 32
) (
  input  logic [WL-1:0] a,
  input  logic [WL-1:0] b,
  output logic [WL-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr wins.
module rr_pick
  import adder_arb_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IDW  = idw_of(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  int unsigned j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr) + k) % 32'(NREQ);
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among NREQ requesters, one result register.
// Define ADD_ARB_OVF_EN to add the registered signed-overflow flag rsp_ovf.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int WL   = DEF_WL,
  parameter int NREQ = DEF_NREQ
) (
  input logic       clk,
  input logic       rst,
  adder_arbiter_if.slave bus
);

  localparam int IDW = idw_of(NREQ);

  arb_state_t      state;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            any;
  logic            slot_free;
  logic            xfer;
  logic [WL-1:0]   op_a;
  logic [WL-1:0]   op_b;
  logic [WL-1:0]   sum;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        op_a = bus.req_in1[i*WL +: WL];
        op_b = bus.req_in2[i*WL +: WL];
      end
    end
  end

  adder #(.WL(WL)) u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  assign slot_free     = (state == ST_EMPTY) || bus.rsp_ready;
  assign xfer          = slot_free && any && !rst;
  assign bus.req_ready = (slot_free && !rst) ? gnt : '0;
  assign bus.rsp_valid = (state == ST_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_EMPTY;
      ptr          <= '0;
      bus.rsp_id   <= '0;
      bus.rsp_data <= '0;
`ifdef ADD_ARB_OVF_EN
      bus.rsp_ovf  <= 1'b0;
`endif
    end else begin
      if (xfer) begin
        state        <= ST_FULL;
        ptr          <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        bus.rsp_id   <= gnt_idx;
        bus.rsp_data <= sum;
`ifdef ADD_ARB_OVF_EN
        bus.rsp_ovf  <= (op_a[WL-1] == op_b[WL-1]) && (sum[WL-1] != op_a[WL-1]);
`endif
      end else if (state == ST_FULL && bus.rsp_ready) begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (WL=32, NREQ=4).
// Overflow checks are active when ADD_ARB_OVF_EN is defined.
module tb_adder_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  adder_arbiter_if #(.WL(32), .NREQ(4)) bus ();

  adder_arbiter #(.WL(32), .NREQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_in1[i*32 +: 32] = a;
    bus.req_in2[i*32 +: 32] = b;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    bus.rsp_ready = 1'b0;

    // reset then idle
    #2;
    check("rst_ready", 64'(bus.req_ready), 64'h0);
    check("rst_valid", 64'(bus.rsp_valid), 64'h0);
    check("rst_id",    64'(bus.rsp_id),    64'h0);
    check("rst_data",  64'(bus.rsp_data),  64'h0);
`ifdef ADD_ARB_OVF_EN
    check("rst_ovf",   64'(bus.rsp_ovf),   64'h0);
`endif
    @(negedge clk); rst = 1'b0;
    after_edge();
    check("idle_valid", 64'(bus.rsp_valid), 64'h0);

    // single request: 5+7 on requester 2
    @(negedge clk);
    set_req(2, 32'd5, 32'd7);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    #1 check("single_ready", 64'(bus.req_ready), 64'h4);
    after_edge();
    check("single_valid", 64'(bus.rsp_valid), 64'h1);
    check("single_id",    64'(bus.rsp_id),    64'h2);
    check("single_data",  64'(bus.rsp_data),  64'd12);
    @(negedge clk); bus.req_valid = '0;
    after_edge();
    check("drain_valid", 64'(bus.rsp_valid), 64'h0);
    check("drain_data",  64'(bus.rsp_data),  64'd12);

    // round robin from ptr=0
    @(negedge clk); rst = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 32'(100*(i+1)), 32'(i));
    bus.req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      #1 check("rr_ready", 64'(bus.req_ready), 64'(4'b0001 << (n % 4)));
      after_edge();
      check("rr_id",   64'(bus.rsp_id),   64'(n % 4));
      check("rr_data", 64'(bus.rsp_data), 64'(101*((n % 4)+1) - 1));
      @(negedge clk);
    end

    // back-pressure: result id0/100 held, ptr stays at 1
    bus.rsp_ready = 1'b0;
    #1 check("bp_ready", 64'(bus.req_ready), 64'h0);
    for (int n = 0; n < 2; n++) begin
      after_edge();
      check("bp_valid", 64'(bus.rsp_valid), 64'h1);
      check("bp_id",    64'(bus.rsp_id),    64'h0);
      check("bp_data",  64'(bus.rsp_data),  64'd100);
    end
    @(negedge clk); bus.rsp_ready = 1'b1;
    #1 check("bp_release_ready", 64'(bus.req_ready), 64'h2);
    after_edge();
    check("bp_next_id",   64'(bus.rsp_id),   64'h1);
    check("bp_next_data", 64'(bus.rsp_data), 64'd201);

    // wrap: ptr=2, only requester 3 valid
    @(negedge clk);
    set_req(3, 32'hFFFF_FFFF, 32'd1);
    bus.req_valid = 4'b1000;
    #1 check("wrap_ready", 64'(bus.req_ready), 64'h8);
    after_edge();
    check("wrap_id",   64'(bus.rsp_id),   64'h3);
    check("wrap_data", 64'(bus.rsp_data), 64'h0);
`ifdef ADD_ARB_OVF_EN
    check("wrap_ovf",  64'(bus.rsp_ovf),  64'h0);
`endif
    @(negedge clk);
    set_req(0, 32'h7FFF_FFFF, 32'd1);
    bus.req_valid = 4'b0001;
    #1 check("ovf_ready", 64'(bus.req_ready), 64'h1);
    after_edge();
    check("ovf_data", 64'(bus.rsp_data), 64'h8000_0000);
`ifdef ADD_ARB_OVF_EN
    check("ovf_flag", 64'(bus.rsp_ovf),  64'h1);
`endif

    // reset mid-stall
    @(negedge clk);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    after_edge();
    check("stall_valid", 64'(bus.rsp_valid), 64'h1);
    @(negedge clk);
    bus.req_valid = 4'b1110;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    #1 check("midrst_valid", 64'(bus.rsp_valid), 64'h0);
    check("midrst_ready", 64'(bus.req_ready), 64'h0);
    check("midrst_data",  64'(bus.rsp_data),  64'h0);
    @(negedge clk); rst = 1'b0;
    #1 check("post_rst_ready", 64'(bus.req_ready), 64'h2);
    after_edge();
    check("post_rst_id", 64'(bus.rsp_id), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
